branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencing controller for the branch unit and the fetch/decode pipeline registers. It registers a taken-branch/jump decision and its target from EX, then drives the PC mux select and write enable on the following cycle while flushing wrong-path instructions from IF/ID, ID/EX and EX/MEM. It also arbitrates load-use stalls and the halt sequence, so the PC register and pipeline registers have a single owner for write-enable and flush.

## Interface
- DRAIN_CYCLES, 3: bubble cycles inserted after a halt request before `halted` asserts; legal 1..15.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- branch_taken  in  1  PcSel from the branch unit (EX stage).
- branch_target  in  32  BrPC from the branch unit; sampled only when branch_taken=1.
- halt_req  in  1  halt decoded in ID (flag_halt).
- load_use_stall  in  1  hazard unit load-use request.
- pc_write  out  1  PC register write enable.
- pc_sel  out  1  0: PC+4, 1: redirect_pc.
- redirect_pc  out  32  registered branch target.
- if_id_write  out  1  IF/ID write enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to NOP (bubble).
- ex_mem_flush  out  1  clear EX/MEM control bits.
- halted  out  1  core frozen.

## Operation
- FSM states: RUN, REDIRECT, DRAIN, HALTED. Reset state RUN.
- Priority within RUN: branch_taken > halt_req > load_use_stall.
- RUN, no request: pc_write=1, if_id_write=1, pc_sel=0, all flushes 0, halted=0.
- RUN, branch_taken=1: redirect_pc <= branch_target; next state REDIRECT. Outputs this cycle are the RUN idle values (decision registered, not combinational).
- RUN, load_use_stall=1 (no branch, no halt): pc_write=0, if_id_write=0, id_ex_flush=1; remain RUN.
- RUN, halt_req=1 (no branch): load drain counter with DRAIN_CYCLES; next state DRAIN.
- REDIRECT (exactly one cycle): pc_sel=1, pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1; next state RUN. branch_taken, halt_req, load_use_stall ignored (wrong-path).
- DRAIN: pc_write=0, if_id_write=0, id_ex_flush=1; counter decrements each cycle; at counter==1 next state HALTED. branch_taken=1 in DRAIN (older branch resolved taken) cancels halt: capture target, next state REDIRECT.
- HALTED: pc_write=0, if_id_write=0, id_ex_flush=1, halted=1; exit only by reset.
- redirect_pc holds its value outside capture cycles; captured verbatim, no alignment.
- Drain counter 4 bits; DRAIN_CYCLES outside 1..15 is a configuration error (elaboration assertion).

## Timing
- Reset (reset_n=0, any time, asynchronous): state RUN, redirect_pc=0, counter=0, counters of the stats option=0; outputs immediately take RUN idle values.
- Branch latency: taken in EX at cycle N -> pc_sel=1 and flushes at cycle N+1 -> target fetched in cycle N+2.
- Penalty: 3 wrong-path instructions (in IF, ID, EX at N+1) killed; none commit.
- Back-to-back branch_taken at N and N+1: second ignored.
- Halt at cycle N -> halted=1 from cycle N+DRAIN_CYCLES+1 onward.
- All outputs are Moore decodes of state plus the RUN stall term; no output depends on branch_target combinationally.

## Configuration
- BRANCH_STATS_EN defined: adds outputs taken_cnt[31:0] (increments on each branch_taken accepted in RUN or DRAIN) and stall_cnt[31:0] (increments each RUN cycle with load_use_stall applied); both wrap at 2^32, freeze in HALTED, clear on reset.
- Undefined: these ports and registers do not exist; remaining behaviour identical.

## Test plan
- Reset: reset_n=0 mid-REDIRECT -> immediately pc_write=1, pc_sel=0, flushes 0, redirect_pc=0.
- Branch: branch_taken=1, branch_target=0x40 at N -> at N+1 pc_sel=1, redirect_pc=0x40, if_id/id_ex/ex_mem_flush=1; at N+2 RUN idle values.
- Back-to-back: branch_taken=1 at N (0x40) and N+1 (0x80) -> only one REDIRECT, redirect_pc stays 0x40.
- Stall vs branch: load_use_stall=1 and branch_taken=1 same cycle -> pc_write=1 (no stall applied), REDIRECT next cycle; load_use_stall alone -> pc_write=0, if_id_write=0, id_ex_flush=1.
- Halt: DRAIN_CYCLES=3, halt_req at N -> pc_write=0 N+1..N+3, halted=1 from N+4, stays set for 20 cycles with random inputs.
- Halt cancel: halt_req at N, branch_taken (0x100) at N+2 -> REDIRECT at N+3 with redirect_pc=0x100, halted never asserts; with BRANCH_STATS_EN, taken_cnt=1.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: single owner of PC / pipeline-register write enables
// and flushes. It registers a taken branch from EX and redirects fetch on the
// next cycle, applies load-use stalls, and sequences halt -> drain -> halted.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   branch_taken          EX branch unit decision (PcSel)
//   branch_target[31:0]   EX branch target (BrPC), captured when accepted
//   halt_req              halt decoded in ID
//   load_use_stall        hazard unit load-use request
//   pc_write, pc_sel      PC register enable and mux select (1: redirect_pc)
//   redirect_pc[31:0]     registered branch target
//   if_id_write           IF/ID enable
//   if_id_flush           IF/ID -> NOP
//   id_ex_flush           ID/EX -> bubble
//   ex_mem_flush          EX/MEM control bits cleared
//   halted                core frozen (left only through reset)
//   taken_cnt, stall_cnt  only with BRANCH_STATS_EN defined
//
// Parameter DRAIN_CYCLES (1..15): bubble cycles between halt_req and halted.
// Optional macro BRANCH_STATS_EN adds the taken_cnt / stall_cnt counters.

module branch_redirect_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic        load_use_stall,
    output logic        pc_write,
    output logic        pc_sel,
    output logic [31:0] redirect_pc,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        halted
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] stall_cnt
`endif
);

    generate
        if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_cfg
            $error("branch_redirect_ctrl: DRAIN_CYCLES must be 1..15");
        end
    endgenerate

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2,
        S_HALTED   = 2'd3
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] redirect_pc_q;
    logic [31:0] redirect_pc_d;
    logic [3:0]  drain_cnt_q;
    logic [3:0]  drain_cnt_d;

    // Pulses used by the optional statistics counters.
    logic        take_br;
    logic        stall_apply;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RUN;
            redirect_pc_q <= 32'd0;
            drain_cnt_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        drain_cnt_d   = drain_cnt_q;
        take_br       = 1'b0;
        stall_apply   = 1'b0;

        pc_write      = 1'b1;
        pc_sel        = 1'b0;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        halted        = 1'b0;

        unique case (state_q)
            S_RUN: begin
                // Branch decision is only registered here; the redirect
                // itself happens in the next cycle.
                if (branch_taken) begin
                    take_br = 1'b1;
                    state_d = S_REDIRECT;
                end else if (halt_req) begin
                    drain_cnt_d = DRAIN_LOAD;
                    state_d     = S_DRAIN;
                end else if (load_use_stall) begin
                    stall_apply = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end

            S_REDIRECT: begin
                // Everything younger than the branch is wrong-path, so the
                // request inputs are not looked at in this state.
                pc_sel       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                state_d      = S_RUN;
            end

            S_DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                // An older branch resolving taken makes the halt itself
                // wrong-path, so the drain is abandoned.
                if (branch_taken) begin
                    take_br     = 1'b1;
                    drain_cnt_d = 4'd0;
                    state_d     = S_REDIRECT;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                    if (drain_cnt_q <= 4'd1) begin
                        state_d = S_HALTED;
                    end
                end
            end

            S_HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                halted      = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase

        if (take_br) begin
            redirect_pc_d = branch_target;
        end
    end

    assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_q;
    logic [31:0] taken_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Both counters wrap naturally; neither pulse can fire in HALTED.
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (take_br) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
        if (stall_apply) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: scoreboard bench for branch_redirect_ctrl.
// Timeline-based reference model; monitor compares every cycle at negedge.

module tb_branch_redirect_ctrl;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    logic        load_use_stall;
    logic        pc_write;
    logic        pc_sel;
    logic [31:0] redirect_pc;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        halted;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    branch_redirect_ctrl #(
        .DRAIN_CYCLES(D)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .load_use_stall(load_use_stall),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .redirect_pc   (redirect_pc),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .halted        (halted)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt     (taken_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [6:0]  ctl;   // pc_write pc_sel if_id_write if_id_flush id_ex_flush ex_mem_flush halted
        logic [31:0] rpc;
        logic [31:0] tcnt;
        logic [31:0] scnt;
        int          cyc;
    } exp_t;

    exp_t expq[$];

    int total = 0;
    int bad   = 0;

    // Reference model: a timeline of absolute cycle numbers.
    int          m_cyc;
    int          m_redir_cyc;
    int          m_halt_at;
    logic [31:0] m_tgt;
    logic [31:0] m_taken;
    logic [31:0] m_stall;

    function automatic logic [6:0] act_ctl();
        return {pc_write, pc_sel, if_id_write, if_id_flush,
                id_ex_flush, ex_mem_flush, halted};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_cyc       = 0;
        m_redir_cyc = -1;
        m_halt_at   = -1;
        m_tgt       = 32'd0;
        m_taken     = 32'd0;
        m_stall     = 32'd0;
    endtask

    task automatic step(input logic br, input logic [31:0] tgt,
                        input logic hr, input logic st);
        exp_t e;
        bit   frozen;
        bit   redir;
        bit   drain;
        bit   run;
        @(posedge clk);
        #1;
        branch_taken   = br;
        branch_target  = tgt;
        halt_req       = hr;
        load_use_stall = st;

        frozen = (m_halt_at >= 0) && (m_cyc >= m_halt_at);
        redir  = (m_cyc == m_redir_cyc);
        drain  = (m_halt_at >= 0) && !frozen && !redir;
        run    = !frozen && !redir && !drain;

        e      = '0;
        e.rpc  = m_tgt;
        e.tcnt = m_taken;
        e.scnt = m_stall;
        e.cyc  = m_cyc;
        if (frozen)
            e.ctl = 7'b0000101;
        else if (redir)
            e.ctl = 7'b1111110;
        else if (drain)
            e.ctl = 7'b0000100;
        else if (!br && !hr && st)
            e.ctl = 7'b0000100;
        else
            e.ctl = 7'b1010000;
        expq.push_back(e);

        if ((run || drain) && br) begin
            m_redir_cyc = m_cyc + 1;
            m_tgt       = tgt;
            m_halt_at   = -1;
            m_taken     = m_taken + 32'd1;
        end else if (run && hr) begin
            m_halt_at = m_cyc + D + 1;
        end else if (run && st) begin
            m_stall = m_stall + 32'd1;
        end
        m_cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom(), 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ctl"}, 64'(act_ctl()), 64'(7'b1010000));
        chk({name, "_rpc"}, 64'(redirect_pc), 64'd0);
`ifdef BRANCH_STATS_EN
        chk({name, "_tcnt"}, 64'(taken_cnt), 64'd0);
        chk({name, "_scnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        branch_taken   = 1'b0;
        halt_req       = 1'b0;
        load_use_stall = 1'b0;
        reset_n        = 1'b0;
        #1;
        chk_reset_vals("reset");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: one expected entry per stimulated cycle.
    always begin : mon
        exp_t e;
        @(negedge clk);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk($sformatf("ctl_c%0d", e.cyc), 64'(act_ctl()), 64'(e.ctl));
            chk($sformatf("rpc_c%0d", e.cyc), 64'(redirect_pc), 64'(e.rpc));
`ifdef BRANCH_STATS_EN
            chk($sformatf("tcnt_c%0d", e.cyc), 64'(taken_cnt), 64'(e.tcnt));
            chk($sformatf("scnt_c%0d", e.cyc), 64'(stall_cnt), 64'(e.scnt));
`endif
        end
    end

    initial begin
        reset_n        = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'd0;
        halt_req       = 1'b0;
        load_use_stall = 1'b0;
        model_clear();
        #3;
        chk_reset_vals("por");
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        idle(2);

        // single branch
        step(1'b1, 32'h40, 1'b0, 1'b0);
        idle(2);

        // back-to-back taken: second one is wrong-path
        step(1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b0);
        idle(2);

        // stall together with branch, then stall alone
        step(1'b1, 32'h44, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);

        // halt then 20+ cycles of random inputs while frozen
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < D + 22; i++)
            step(1'($urandom()), $urandom(), 1'($urandom()), 1'($urandom()));
        do_reset();

        // halt cancelled by an older taken branch
        step(1'b0, 32'h0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 32'h100, 1'b0, 1'b0);
        idle(8);

        // reset asserted in the middle of a REDIRECT cycle
        step(1'b1, 32'h200, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        branch_taken = 1'b0;
        chk("pre_reset_redirect", 64'(pc_sel), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_redirect_reset");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(5) == 0, $urandom(),
                 $urandom_range(39) == 0, $urandom_range(3) == 0);
            if (m_halt_at >= 0 && m_cyc >= m_halt_at + 20) do_reset();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
